// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction fetch stage.
//   fetch_state_t    - 2-bit FSM encoding (S_REQ, S_WAIT, S_OUT)
//   RESET_PC_DEFAULT - default reset fetch address
//   FAULT_INST       - instruction word presented with a fault
//   ALIGN_MASK       - low PC bits that must be zero for a word fetch
//   is_misaligned    - alignment check on the low PC bits
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] FAULT_INST       = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return |(lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: handshake bundle around the fetch stage.
//   imem_req_*    - single-outstanding read request to instruction memory
//   imem_resp_*   - read response (data + access fault), one per request
//   redirect_*    - PC redirect from the core (branch/jump/trap)
//   inst_*        - fetched instruction presented to the core
// master: the fetch stage; slave: memory + core side.
interface ifu_fetch_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            imem_resp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data, imem_resp_err,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, inst_fault,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data, imem_resp_err,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_fault,
    output inst_ready
  );

endinterface

// File: rtl/ifu_fetch_pc_gen.sv
// fetch_pc_gen: combinational next-PC selection for the fetch stage.
//   pc                  - current architectural fetch PC
//   advance             - instruction consumed by the core (pc + 4)
//   redirect_valid/pc   - redirect request, highest priority
//   next_pc             - PC to load on the next edge
//   redirect_misaligned - redirect target is not word aligned
module fetch_pc_gen
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect_misaligned
);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = pc + XLEN'(4);
    end
    redirect_misaligned = redirect_valid && is_misaligned(redirect_pc[1:0]);
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding a single-cycle core.
//   clk, rst - clock; synchronous active-low reset
//   bus      - ifu_fetch_if master: imem request/response, redirect,
//              and the instruction handshake to the core
// One memory request outstanding at a time. kill marks an in-flight
// response that a redirect has made stale; it is dropped on arrival.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic       clk,
  input  logic       rst,
  ifu_fetch_if.master bus
);

  fetch_state_t    state;
  logic            kill;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            req_fire;
  logic            inst_fire;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] inst_pc_r;
  logic            inst_fault_r;

  // While kill is set a stale response is still owed by memory, so a new
  // request is held back to keep a single request outstanding.
  assign bus.imem_req_valid = rst && (state == S_REQ) && !kill;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (state == S_OUT);
  assign bus.inst           = inst_r;
  assign bus.inst_pc        = inst_pc_r;
  assign bus.inst_fault     = inst_fault_r;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign inst_fire = (state == S_OUT) && bus.inst_ready;

  fetch_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc                  (pc),
    .advance             (inst_fire),
    .redirect_valid      (bus.redirect_valid),
    .redirect_pc         (bus.redirect_pc),
    .next_pc             (next_pc),
    .redirect_misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      inst_r       <= '0;
      inst_pc_r    <= RESET_PC;
      inst_fault_r <= 1'b0;
    end else begin
      pc <= next_pc;
      unique case (state)
        S_REQ: begin
          if (bus.imem_resp_valid && kill) kill <= 1'b0;
          if (req_fire && bus.redirect_valid) kill <= 1'b1;
          if (req_fire) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            kill <= !bus.imem_resp_valid;
            if (bus.imem_resp_valid) state <= S_REQ;
          end else if (bus.imem_resp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              inst_r       <= bus.imem_resp_err ? XLEN'(FAULT_INST) : bus.imem_resp_data;
              inst_fault_r <= bus.imem_resp_err;
              inst_pc_r    <= pc;
              state        <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.imem_resp_valid && kill) kill <= 1'b0;
          if (bus.redirect_valid || inst_fire) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
      // A misaligned redirect overrides the per-state next state from any
      // state: the fault is presented directly, kill handled above.
      if (misaligned) begin
        inst_r       <= XLEN'(FAULT_INST);
        inst_pc_r    <= bus.redirect_pc;
        inst_fault_r <= 1'b1;
        state        <= S_OUT;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: cycle-table bench for ifu_fetch with a small
// variable-latency instruction memory model.
module tb_ifu_fetch;

  localparam logic [31:0] R        = 32'h8000_0000;
  localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

  logic clk;
  logic rst;

  ifu_fetch_if #(.XLEN(32)) b ();

  ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    int          lat;
    logic        rv;
    logic [31:0] rpc;
    logic        ir;
    logic        chk;
    logic        full;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  int n_chk  = 0;
  int n_fail = 0;

  // memory model state
  logic        pend = 1'b0;
  int          cnt  = 0;
  int          cur_lat = 1;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0093;
      32'h8000_0004: return 32'h0010_0113;
      32'h8000_0010: return 32'hDEAD_BEEF;
      32'h8000_0100: return 32'h0050_0293;
      default:       return {a[15:0], 16'h0013};
    endcase
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic rs, rdy, input int lat, input logic rv,
                     input logic [31:0] rpc, input logic ir, input logic chk, full,
                     input logic e_rqv, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_inst, e_ipc, input logic e_flt);
    vec_t v;
    v.rst = rs; v.rdy = rdy; v.lat = lat; v.rv = rv; v.rpc = rpc; v.ir = ir;
    v.chk = chk; v.full = full; v.e_rqv = e_rqv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_flt = e_flt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rs, rdy, input int lat, input logic rv,
                       input logic [31:0] rpc, input logic ir);
    rst              = rs;
    b.imem_req_ready = rdy;
    cur_lat          = lat;
    b.redirect_valid = rv;
    b.redirect_pc    = rpc;
    b.inst_ready     = ir;
    #1;
  endtask

  // Advance one cycle: record an acceptance, cross the edge, then drive the
  // memory response for the new cycle.
  task automatic tick();
    logic acc, r;
    acc = b.imem_req_valid && b.imem_req_ready;
    r   = rst;
    if (acc) begin
      chk1("one_outstanding", pend, 1'b0);
      pend  = 1'b1;
      cnt   = cur_lat;
      paddr = b.imem_req_addr;
    end
    @(posedge clk);
    @(negedge clk);
    b.imem_resp_valid = 1'b0;
    b.imem_resp_data  = '0;
    b.imem_resp_err   = 1'b0;
    if (!r) begin
      pend = 1'b0;
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        b.imem_resp_valid = 1'b1;
        b.imem_resp_data  = mem_word(paddr);
        b.imem_resp_err   = (paddr == ERR_ADDR);
        pend              = 1'b0;
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    b.imem_req_ready  = 1'b0;
    b.imem_resp_valid = 1'b0;
    b.imem_resp_data  = '0;
    b.imem_resp_err   = 1'b0;
    b.redirect_valid  = 1'b0;
    b.redirect_pc     = '0;
    b.inst_ready      = 1'b0;

    //  rst rdy lat rv rpc      ir  chk full  rqv addr     iv inst          ipc      flt
    add(0, 1, 1, 0, 0,        1,  0, 0,    0, 0,        0, 0,            0,       0); // t0
    add(0, 1, 1, 0, 0,        1,  1, 1,    0, 0,        0, 0,            R,       0); // t1 reset
    add(1, 1, 1, 0, 0,        1,  1, 0,    1, R,        0, 0,            0,       0); // t2 first req
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t3 resp
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        1, 32'h93,       R,       0); // t4 inst
    add(1, 1, 1, 0, 0,        0,  1, 0,    1, R+4,      0, 0,            0,       0); // t5
    add(1, 1, 1, 0, 0,        0,  1, 0,    0, 0,        0, 0,            0,       0); // t6
    for (int k = 0; k < 5; k++)                                                     // t7-11 stall
      add(1, 1, 1, 0, 0,      0,  1, 0,    0, 0,        1, 32'h00100113, R+4,     0);
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        1, 32'h00100113, R+4,     0); // t12 consume
    add(1, 1, 1, 0, 0,        1,  1, 0,    1, R+8,      0, 0,            0,       0); // t13 err addr
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t14
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        1, 0,            R+8,     1); // t15 fault
    add(1, 1, 1, 0, 0,        1,  1, 0,    1, R+12,     0, 0,            0,       0); // t16
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t17
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        1, 32'h000C0013, R+12,    0); // t18
    add(1, 1, 4, 0, 0,        1,  1, 0,    1, R+16,     0, 0,            0,       0); // t19 slow req
    add(1, 1, 1, 1, R+32'h100,1,  1, 0,    0, 0,        0, 0,            0,       0); // t20 redirect
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t21
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t22
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t23 stale resp
    add(1, 1, 1, 0, 0,        1,  1, 0,    1, R+32'h100,0, 0,            0,       0); // t24
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t25
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        1, 32'h00500293, R+32'h100, 0); // t26
    add(1, 0, 1, 1, R+32'h102,1,  1, 0,    1, R+32'h104,0, 0,            0,       0); // t27 misaligned
    add(1, 0, 1, 0, 0,        0,  1, 0,    0, 0,        1, 0,            R+32'h102, 1); // t28
    add(1, 0, 1, 0, 0,        1,  1, 0,    0, 0,        1, 0,            R+32'h102, 1); // t29
    add(1, 0, 1, 1, R+32'h200,1,  1, 0,    1, R+32'h106,0, 0,            0,       0); // t30 addr change
    add(1, 1, 2, 0, 0,        1,  1, 0,    1, R+32'h200,0, 0,            0,       0); // t31
    add(1, 1, 1, 1, R+32'h301,1,  1, 0,    0, 0,        0, 0,            0,       0); // t32 misaligned in wait
    add(1, 1, 1, 0, 0,        0,  1, 0,    0, 0,        1, 0,            R+32'h301, 1); // t33 absorb
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        1, 0,            R+32'h301, 1); // t34
    add(1, 1, 1, 1, R+32'h400,1,  1, 0,    1, R+32'h305,0, 0,            0,       0); // t35 accept+redirect
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t36
    add(1, 1, 1, 0, 0,        1,  1, 0,    1, R+32'h400,0, 0,            0,       0); // t37
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t38
    add(1, 1, 1, 1, R+32'h500,1,  1, 0,    0, 0,        1, 32'h04000013, R+32'h400, 0); // t39 fire+redirect
    add(1, 1, 1, 0, 0,        1,  1, 0,    1, R+32'h500,0, 0,            0,       0); // t40
    add(1, 1, 1, 1, R+32'h600,1,  1, 0,    0, 0,        0, 0,            0,       0); // t41 resp+redirect
    add(1, 1, 1, 0, 0,        1,  1, 0,    1, R+32'h600,0, 0,            0,       0); // t42
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t43
    add(1, 1, 1, 0, 0,        1,  1, 0,    0, 0,        1, 32'h06000013, R+32'h600, 0); // t44
    add(1, 1, 3, 0, 0,        1,  1, 0,    1, R+32'h604,0, 0,            0,       0); // t45
    add(0, 1, 1, 0, 0,        1,  1, 0,    0, 0,        0, 0,            0,       0); // t46 reset in wait
    add(0, 1, 1, 0, 0,        1,  1, 1,    0, 0,        0, 0,            R,       0); // t47
    add(1, 0, 1, 0, 0,        1,  1, 1,    1, R,        0, 0,            R,       0); // t48 release

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].lat, vecs[i].rv, vecs[i].rpc, vecs[i].ir);
      if (vecs[i].chk) begin
        chk1($sformatf("t%0d.req_valid", i), b.imem_req_valid, vecs[i].e_rqv);
        if (vecs[i].e_rqv)
          chk32($sformatf("t%0d.req_addr", i), b.imem_req_addr, vecs[i].e_addr);
        chk1($sformatf("t%0d.inst_valid", i), b.inst_valid, vecs[i].e_iv);
        if (vecs[i].e_iv || vecs[i].full) begin
          chk32($sformatf("t%0d.inst", i), b.inst, vecs[i].e_inst);
          chk32($sformatf("t%0d.inst_pc", i), b.inst_pc, vecs[i].e_ipc);
          chk1($sformatf("t%0d.inst_fault", i), b.inst_fault, vecs[i].e_flt);
        end
      end
      tick();
    end

    // Double redirect while waiting (kill already set), then PC wrap.
    drive(1, 1, 3, 1, 32'hFFFF_FFF8, 1);
    chk1("w1.req_valid", b.imem_req_valid, 1'b1);
    chk32("w1.req_addr", b.imem_req_addr, R);
    tick();
    drive(1, 1, 1, 1, 32'hFFFF_FFFC, 1);
    chk1("w2.req_valid", b.imem_req_valid, 1'b0);
    tick();
    drive(1, 1, 1, 0, 0, 1);
    chk1("w3.req_valid", b.imem_req_valid, 1'b0);
    tick();
    drive(1, 1, 1, 0, 0, 1);
    chk1("w4.stale_resp", b.imem_resp_valid, 1'b1);
    chk1("w4.inst_valid", b.inst_valid, 1'b0);
    tick();
    drive(1, 1, 1, 0, 0, 1);
    chk1("w5.req_valid", b.imem_req_valid, 1'b1);
    chk32("w5.req_addr", b.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    drive(1, 1, 1, 0, 0, 1);
    chk1("w6.inst_valid", b.inst_valid, 1'b0);
    tick();
    drive(1, 1, 1, 0, 0, 1);
    chk1("w7.inst_valid", b.inst_valid, 1'b1);
    chk32("w7.inst", b.inst, 32'hFFFC_0013);
    chk32("w7.inst_pc", b.inst_pc, 32'hFFFF_FFFC);
    tick();
    drive(1, 0, 1, 0, 0, 1);
    chk1("w8.req_valid", b.imem_req_valid, 1'b1);
    chk32("w8.req_addr_wrap", b.imem_req_addr, 32'h0000_0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
